// File: rtl/rstseq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package rstseq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [7:0] RETRY_MAX = 8'd255;

  // Sizes the shared phase counter so it holds the largest terminal count.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rstseq_sync2.sv
// Two-flop synchroniser with asynchronous active-low clear, used for pll_locked.
module rstseq_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: flops take non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases the domain resets in order.
// Define RSTSEQ_SOFT_RST_EN to add the soft_rst_req input (full re-sequence without a retry count).
module pll_reset_sequencer
  import rstseq_pkg::*;
#(
  parameter int NUM_DOMAINS         = 9,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGE_GAP_CYCLES    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
`ifdef RSTSEQ_SOFT_RST_EN
  input  logic                   soft_rst_req,
`endif
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] sys_rst_n,
  output logic                   ready,
  output logic [7:0]             retry_cnt
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STAGE_GAP_CYCLES) + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [STB_W-1:0]       stable_q, stable_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] sys_rst_n_q, sys_rst_n_d;
  logic                   ready_q, ready_d;
  logic [7:0]             retry_q, retry_d;
  logic                   retry_inc;
  logic                   lk;
  logic                   soft_req;

  rstseq_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked),
    .q_o   (lk)
  );

`ifdef RSTSEQ_SOFT_RST_EN
  assign soft_req = soft_rst_req;
`else
  assign soft_req = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stable_d    = '0;
    idx_d       = idx_q;
    sys_rst_n_d = sys_rst_n_q;
    retry_d     = retry_q;
    retry_inc   = 1'b0;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        cnt_d    = cnt_q + 1'b1;
        stable_d = lk ? stable_q + 1'b1 : '0;
        // Stable lock is tested first so it wins over a coincident timeout.
        if (lk && stable_q == STABLE_LAST) begin
          state_d        = RELEASE;
          cnt_d          = '0;
          stable_d       = '0;
          idx_d          = '0;
          sys_rst_n_d[0] = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = PLL_RST;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
      end
      RELEASE: begin
        if (idx_q == IDX_LAST) begin
          state_d = RUN;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d              = '0;
          idx_d              = idx_q + 1'b1;
          sys_rst_n_d[idx_d] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
      end
    endcase

    // Lock loss (counted) or soft request (not counted) aborts any released state.
    if ((state_q == RELEASE || state_q == RUN) && (!lk || soft_req)) begin
      state_d     = PLL_RST;
      cnt_d       = '0;
      idx_d       = '0;
      sys_rst_n_d = '0;
      retry_inc   = !lk;
    end

    if (retry_inc && retry_q != RETRY_MAX) begin
      retry_d = retry_q + 1'b1;
    end

    pll_rst_d = (state_d == PLL_RST);
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      stable_q    <= '0;
      idx_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= '0;
      ready_q     <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      idx_q       <= idx_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      retry_q     <= retry_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with shortened timing parameters; build with RSTSEQ_SOFT_RST_EN to cover soft_rst_req.
module tb_pll_reset_sequencer;

  localparam int N = 9;
  localparam int P = 4;
  localparam int S = 12;
  localparam int T = 40;
  localparam int G = 3;
`ifdef RSTSEQ_SOFT_RST_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pll_locked = 1'b1;
  logic         soft_rst_req = 1'b0;
  logic         pll_rst;
  logic [N-1:0] sys_rst_n;
  logic         ready;
  logic [7:0]   retry_cnt;

  int n_pass = 0;
  int n_checks = 0;

  always #10 clk = ~clk;

  pll_reset_sequencer #(
    .NUM_DOMAINS         (N),
    .PLL_RST_CYCLES      (P),
    .LOCK_STABLE_CYCLES  (S),
    .LOCK_TIMEOUT_CYCLES (T),
    .STAGE_GAP_CYCLES    (G)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
`ifdef RSTSEQ_SOFT_RST_EN
    .soft_rst_req (soft_rst_req),
`endif
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .retry_cnt    (retry_cnt)
  );

  // Reference model: phase (0 pll reset, 1 wait lock, 2 release, 3 run), time spent in
  // the phase, run length of consecutive synced lock, and the retry total.
  int m_mode, m_t, m_run, m_retry;
  bit s1, s2;

  function automatic void model_reset();
    m_mode = 0; m_t = 0; m_run = 0; m_retry = 0; s1 = 1'b0; s2 = 1'b0;
  endfunction

  function automatic void model_step();
    bit lk;
    if (!rst_n) begin
      model_reset();
    end else begin
      lk = s2; s2 = s1; s1 = pll_locked;
      case (m_mode)
        0: begin
          m_t++;
          if (m_t == P) begin m_mode = 1; m_t = 0; m_run = 0; end
        end
        1: begin
          m_t++;
          m_run = lk ? m_run + 1 : 0;
          if (m_run == S) begin
            m_mode = 2; m_t = 0;
          end else if (m_t == T) begin
            m_mode = 0; m_t = 0;
            if (m_retry < 255) m_retry++;
          end
        end
        default: begin
          if (!lk || (SOFT_EN && soft_rst_req)) begin
            if (!lk && m_retry < 255) m_retry++;
            m_mode = 0; m_t = 0;
          end else if (m_mode == 2) begin
            m_t++;
            if (m_t == (N - 1) * G + 1) m_mode = 3;
          end
        end
      endcase
    end
  endfunction

  function automatic logic [31:0] pk(input logic pr, input logic rd, input logic [N-1:0] sys,
                                     input logic [7:0] rc);
    return {13'd0, pr, rd, sys, rc};
  endfunction

  function automatic logic [31:0] model_out();
    logic [N-1:0] sys;
    int rel;
    sys = '0;
    if (m_mode == 3) begin
      sys = '1;
    end else if (m_mode == 2) begin
      rel = m_t / G + 1;
      if (rel > N) rel = N;
      for (int i = 0; i < rel; i++) sys[i] = 1'b1;
    end
    return pk(m_mode == 0, m_mode == 3, sys, m_retry[7:0]);
  endfunction

  function automatic logic [31:0] dut_out();
    return pk(pll_rst, ready, sys_rst_n, retry_cnt);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", dut_out(), model_out());
  endtask

  typedef struct {
    logic        rst_n;
    logic        locked;
    int          cycles;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vec[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    model_reset();

    vec[0]  = '{1'b0, 1'b1, 5,  pk(1, 0, 9'h000, 0), "reset_values"};
    vec[1]  = '{1'b1, 1'b1, 3,  pk(1, 0, 9'h000, 0), "pll_rst_hold"};
    vec[2]  = '{1'b1, 1'b1, 1,  pk(0, 0, 9'h000, 0), "wait_lock_entry"};
    vec[3]  = '{1'b1, 1'b1, S,  pk(0, 0, 9'h001, 0), "bit0_release"};
    vec[4]  = '{1'b1, 1'b1, G,  pk(0, 0, 9'h003, 0), "bit1_release"};
    vec[5]  = '{1'b1, 1'b1, 21, pk(0, 0, 9'h1ff, 0), "last_bit_release"};
    vec[6]  = '{1'b1, 1'b1, 1,  pk(0, 1, 9'h1ff, 0), "run_ready"};
    vec[7]  = '{1'b1, 1'b0, 2,  pk(0, 1, 9'h1ff, 0), "lock_sync_delay"};
    vec[8]  = '{1'b1, 1'b0, 1,  pk(1, 0, 9'h000, 1), "lock_loss_in_run"};
    vec[9]  = '{1'b1, 1'b0, 43, pk(0, 0, 9'h000, 1), "timeout_pending"};
    vec[10] = '{1'b1, 1'b0, 1,  pk(1, 0, 9'h000, 2), "timeout_retry"};
    vec[11] = '{1'b1, 1'b0, 44, pk(1, 0, 9'h000, 3), "third_retry"};

    for (int i = 0; i < 12; i++) begin
      rst_n      = vec[i].rst_n;
      pll_locked = vec[i].locked;
      repeat (vec[i].cycles) tick();
      check(vec[i].name, dut_out(), vec[i].exp);
    end

    // Asynchronous reset while the fifth domain (idx 4) has just been released.
    pll_locked = 1'b1;
    n = 0;
    while (!(m_mode == 2 && m_t / G == 4) && n < 300) begin tick(); n++; end
    check("reach_release_idx4", 32'(n < 300), 32'd1);
    check("idx4_released", 32'(sys_rst_n), 32'h01f);
    rst_n = 1'b0;
    #1;
    check("async_reset_values", dut_out(), pk(1, 0, 9'h000, 0));
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (P - 1) tick();
    check("restart_pll_rst", 32'(pll_rst), 32'd1);
    tick();
    check("restart_wait_lock", 32'(pll_rst), 32'd0);

    // One-cycle lock glitch while the stable count is building.
    n = 0;
    while (!(m_mode == 1 && m_run == S - 6) && n < 100) begin tick(); n++; end
    check("reach_stable_count", 32'(n < 100), 32'd1);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    n = 1;
    while (!sys_rst_n[0] && n < 100) begin tick(); n++; end
    check("glitch_release_latency", 32'(n), 32'(S + 3));

`ifdef RSTSEQ_SOFT_RST_EN
    n = 0;
    while (m_mode != 3 && n < 200) begin tick(); n++; end
    check("reach_run", 32'(ready), 32'd1);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("soft_in_run", dut_out(), pk(1, 0, 9'h000, 0));
    repeat (P) tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("soft_in_wait_ignored", dut_out(), pk(0, 0, 9'h000, 0));
`endif

    // Random lock behaviour with occasional soft requests, checked against the model every cycle.
    n = 0;
    while (n < 1500) begin
      int dur;
      pll_locked = ($urandom_range(0, 3) != 0);
      dur = $urandom_range(1, 2 * S + N * G);
      for (int k = 0; k < dur; k++) begin
        soft_rst_req = SOFT_EN && ($urandom_range(0, 40) == 0);
        tick();
        n++;
      end
    end
    soft_rst_req = 1'b0;

    // Retry counter saturation under a permanently missing lock.
    pll_locked = 1'b0;
    repeat (256 * (P + T) + 50) tick();
    check("retry_saturate", 32'(retry_cnt), 32'd255);
    repeat (P + T) tick();
    check("retry_hold", 32'(retry_cnt), 32'd255);
    check("no_release_unlocked", 32'(sys_rst_n), 32'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
